// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by the byte bus interface, the byte packer and the loader FSM.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_SHIFT     = 2;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port.
// master = host/memory side, slave = the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                          byte_valid;
    logic [7:0]                    byte_data;
    logic                          byte_ready;
    logic                          mem_we;
    logic [31:0]                   mem_addr;
    logic [8*BYTES_PER_WORD-1:0]   mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian packer: each loaded byte fills lane byte_cnt of the word,
// lane 0 being bits [7:0]; last flags that the next load completes the word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        load,
    input  logic [7:0]                  byte_in,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic                        last
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_cnt;

    // NOTE: the word register is reset too because it drives mem_wdata, whose reset value is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            word_out <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (load) begin
            // NOTE: non-blocking so byte_cnt selects the lane with its pre-edge value.
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (byte_cnt == CNT_W'(i)) begin
                    word_out[8*i +: 8] <= byte_in;
                end
            end
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    assign last = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs host bytes into words, writes them to the instruction
// memory and holds the CPU off until the whole program is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int NUM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       len,
    input  logic              abort,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    loader_state_t              state_q;
    loader_state_t              state_d;
    logic [IDX_W-1:0]           word_idx;
    logic [IDX_W-1:0]           last_idx;
    logic [8*BYTES_PER_WORD-1:0] word;
    logic                       word_last;
    logic                       len_ok;
    logic                       accept;
    logic                       cut;
    logic                       xfer;

    // Length is range-checked at full width before truncation into last_idx.
    assign len_ok = (len != 32'd0) && (len <= 32'(NUM_WORDS));
    assign accept = (state_q == IDLE) && start && len_ok;
    assign cut    = ((state_q == RECV) || (state_q == WRITE)) && abort;
    assign xfer   = (state_q == RECV) && bus.byte_valid && !abort;

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept || cut),
        .load     (xfer),
        .byte_in  (bus.byte_data),
        .word_out (word),
        .last     (word_last)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RECV;
            RECV: begin
                if (abort)                  state_d = IDLE;
                else if (xfer && word_last) state_d = WRITE;
            end
            WRITE: begin
                if (abort)                  state_d = IDLE;
                else if (word_idx == last_idx) state_d = DONE;
                else                        state_d = RECV;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            word_idx <= '0;
            last_idx <= '0;
            error    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_idx <= '0;
                last_idx <= IDX_W'(len - 32'd1);
            end else if ((state_q == WRITE) && !abort && (word_idx != last_idx)) begin
                word_idx <= word_idx + IDX_W'(1);
            end

            if (accept) begin
                error <= 1'b0;
            end else if (((state_q == IDLE) && start && !len_ok) || cut) begin
                error <= 1'b1;
            end
        end
    end

    assign bus.byte_ready = (state_q == RECV);
    // abort must suppress a write in the same cycle, so it is the one input gating an output.
    assign bus.mem_we     = (state_q == WRITE) && !abort;
    assign bus.mem_addr   = 32'(word_idx) << ADDR_SHIFT;
    assign bus.mem_wdata  = word;
    assign cpu_hold       = (state_q != IDLE);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are derived
// from the byte stream and checked by an independent negedge monitor.
module tb_imem_loader;

    typedef enum {CUT_NONE, CUT_ABORT, CUT_RESET} cut_e;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] len;
    logic        abort;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader_if bus ();

    imem_loader #(.NUM_WORDS(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   done_cnt = 0;
    int   last_we_cyc = 0;
    int   last_done_cyc = 0;
    wr_t  exp_q[$];
    logic [7:0] byte_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every memory write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.byte_valid && bus.byte_ready) xfer_cnt++;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (bus.mem_we) begin
            last_we_cyc = cyc;
            check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %h data %h with empty scoreboard", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bus.mem_addr, e.addr);
                check("write_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check("rst_mem_addr",   bus.mem_addr,        32'd0);
        check("rst_mem_wdata",  bus.mem_wdata,       32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),       32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_done",       32'(done),           32'd0);
        check("rst_error",      32'(error),          32'd0);
    endtask

    // All tasks start and end just after a rising edge (cycle boundary + 1).
    task automatic run_load(input int n, input int stall, input cut_e cut_kind,
                            input int cut_at, input bit busy_start);
        int  total, nwr, sent, budget, t0, x0, d0;
        bit  xfer;
        wr_t w;
        total = (cut_kind == CUT_NONE) ? 4 * n : cut_at;
        nwr   = total / 4;
        if (cut_kind == CUT_ABORT && (total % 4) == 0) nwr = nwr - 1;
        while (byte_q.size() < 4 * n) byte_q.push_back(8'($urandom));
        for (int k = 0; k < nwr; k++) begin
            w.addr = 32'(k * 4);
            w.data = {byte_q[4*k+3], byte_q[4*k+2], byte_q[4*k+1], byte_q[4*k]};
            exp_q.push_back(w);
        end
        x0 = xfer_cnt;
        d0 = done_cnt;
        start = 1'b1;
        len   = 32'(n);
        t0    = cyc;
        sent  = 0;
        budget = 32 * n + 50;
        while (sent < total && budget > 0) begin
            case (stall)
                0:       bus.byte_valid = 1'b1;
                1:       bus.byte_valid = ((cyc - t0) % 2) == 0;
                default: bus.byte_valid = 1'($urandom_range(0, 1));
            endcase
            bus.byte_data = byte_q[sent];
            @(negedge clk);
            if (cyc == t0 + 1) begin
                check("c1_busy",       32'(busy),           32'd1);
                check("c1_cpu_hold",   32'(cpu_hold),       32'd1);
                check("c1_byte_ready", 32'(bus.byte_ready), 32'd1);
                check("c1_error",      32'(error),          32'd0);
            end
            xfer = bus.byte_valid && bus.byte_ready;
            @(posedge clk); #1;
            if (xfer) sent++;
            start = busy_start && (sent == 5);
            if (start) len = 32'd1;
            budget--;
        end
        start = 1'b0;
        bus.byte_valid = 1'b0;
        if (budget == 0) check("feed_timeout_bytes", 32'(sent), 32'(total));

        if (cut_kind == CUT_ABORT) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
            check("abort_busy",     32'(busy),     32'd0);
            check("abort_error",    32'(error),    32'd1);
        end else if (cut_kind == CUT_RESET) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check_reset_values();
        end else begin
            budget = 20;
            while (done_cnt == d0 && budget > 0) begin
                @(posedge clk); #1;
                budget--;
            end
            check("done_seen", 32'(done_cnt - d0), 32'd1);
            @(negedge clk);
            check("after_done_cpu_hold", 32'(cpu_hold), 32'd0);
            check("after_done_busy",     32'(busy),     32'd0);
            if (stall == 0) begin
                check("done_cycle",      32'(last_done_cyc - t0), 32'(5 * n + 1));
                check("last_write_cycle", 32'(last_we_cyc - t0),  32'(5 * n));
            end
        end
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("transfer_count",     32'(xfer_cnt - x0), 32'(total));
        check("done_pulses",        32'(done_cnt - d0), (cut_kind == CUT_NONE) ? 32'd1 : 32'd0);
        byte_q.delete();
    endtask

    task automatic illegal_start(input logic [31:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("illegal_error",      32'(error),          32'd1);
        check("illegal_busy",       32'(busy),           32'd0);
        check("illegal_cpu_hold",   32'(cpu_hold),       32'd0);
        check("illegal_byte_ready", 32'(bus.byte_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        len   = 32'd0;
        abort = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;

        // Single word, back-to-back bytes
        byte_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_load(1, 0, CUT_NONE, 0, 1'b0);

        // Three words with byte_valid toggling
        run_load(3, 1, CUT_NONE, 0, 1'b0);

        // Illegal lengths; the next legal start must clear error
        illegal_start(32'd0);
        illegal_start(32'd65);
        illegal_start(32'h8000_0002);
        run_load(1, 2, CUT_NONE, 0, 1'b0);

        // abort in IDLE is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_error", 32'(error), 32'd0);
        check("idle_abort_busy",  32'(busy),  32'd0);
        @(posedge clk); #1;

        // abort after 2 bytes of word 1, then abort in the WRITE of word 1
        run_load(4, 0, CUT_ABORT, 6, 1'b0);
        run_load(4, 2, CUT_ABORT, 8, 1'b0);

        // reset in RECV of word 2
        run_load(4, 0, CUT_RESET, 9, 1'b0);

        // start while busy is ignored
        run_load(2, 0, CUT_NONE, 0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_load($urandom_range(1, 8), $urandom_range(0, 2), CUT_NONE, 0, 1'b0);
        end

        // Maximum length
        run_load(64, 0, CUT_NONE, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
